// File: rtl/ram_write_combiner_pkg.sv
// Shared definitions for the ZX RAM write combiner: line geometry, FSM states,
// line-buffer operations and the line-address extract helper.
package ram_write_combiner_pkg;

    localparam int unsigned LINE_BYTES  = 8;
    localparam int unsigned LINE_ADDR_W = 18;
    localparam int unsigned BYTE_ADDR_W = 21;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        FLUSH
    } wc_state_t;

    typedef enum logic [1:0] {
        BUF_HOLD,
        BUF_MERGE,
        BUF_CLEAR,
        BUF_LOAD
    } buf_op_t;

    // Line address of a byte address (drops the 3-bit byte offset).
    function automatic logic [LINE_ADDR_W-1:0] line_of(input logic [BYTE_ADDR_W-1:0] a);
        return a[BYTE_ADDR_W-1:3];
    endfunction

endpackage

// File: rtl/ram_write_combiner_if.sv
// Line write bus from the combiner (master) to the memory controller (slave).
interface ram_write_combiner_if;
    import ram_write_combiner_pkg::*;

    logic [LINE_ADDR_W-1:0]  mem_addr;
    logic [LINE_BYTES*8-1:0] mem_data;
    logic [LINE_BYTES-1:0]   mem_strb;
    logic                    mem_valid;
    logic                    mem_ready;

    modport master (
        output mem_addr,
        output mem_data,
        output mem_strb,
        output mem_valid,
        input  mem_ready
    );

    modport slave (
        input  mem_addr,
        input  mem_data,
        input  mem_strb,
        input  mem_valid,
        output mem_ready
    );

endinterface

// File: rtl/ram_wc_line_buffer.sv
// 64-bit line data plus byte strobes; supports byte merge, clear and
// load-single (fresh line holding one byte, all other bytes zero).
module ram_wc_line_buffer
    import ram_write_combiner_pkg::*;
(
    input  logic                    clk_memory,
    input  logic                    reset_n,
    input  buf_op_t                 op,
    input  logic [2:0]              off,
    input  logic [7:0]              byte_in,
    output logic [LINE_BYTES*8-1:0] line_data,
    output logic [LINE_BYTES-1:0]   line_strb
);

    // Apply the requested operation to the line registers.
    always_ff @(posedge clk_memory or negedge reset_n) begin
        if (!reset_n) begin
            line_data <= '0;
            line_strb <= '0;
        end else begin
            case (op)
                BUF_MERGE: begin
                    line_data[{off, 3'b000} +: 8] <= byte_in;
                    line_strb[off]                <= 1'b1;
                end
                BUF_CLEAR: begin
                    line_data <= '0;
                    line_strb <= '0;
                end
                BUF_LOAD: begin
                    line_data <= {56'd0, byte_in} << {off, 3'b000};
                    line_strb <= 8'b1 << off;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ram_write_combiner.sv
// Combines single-byte writes into 64-bit line writes with byte strobes.
// Optional idle-timeout flush: define RAM_WRITE_TIMEOUT_EN.
module ram_write_combiner
    import ram_write_combiner_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                   clk_memory,
    input  logic                   reset_n,
    input  logic [BYTE_ADDR_W-1:0] addr,
    input  logic [7:0]             data,
    input  logic                   wr,
    input  logic                   flush,
    output logic                   busy,
    input  logic [BYTE_ADDR_W-1:0] rd_addr,
    output logic                   rd_hit,
    ram_write_combiner_if.master   mem
);

    wc_state_t              state, next_state;
    logic [LINE_ADDR_W-1:0] line;
    logic                   pend_valid;
    logic [LINE_ADDR_W-1:0] pend_line;
    logic [2:0]             pend_off;
    logic [7:0]             pend_byte;

    buf_op_t                 buf_op;
    logic [2:0]              buf_off;
    logic [7:0]              buf_byte;
    logic [LINE_BYTES*8-1:0] line_data;
    logic [LINE_BYTES-1:0]   line_strb;
    logic [LINE_BYTES-1:0]   merged_strb;

    logic accept, same_line, timeout_hit;
    logic line_ld, pend_set, pend_clr;
    logic unused_rd_off;

    assign unused_rd_off = ^rd_addr[2:0];

    assign busy        = pend_valid || (state == FLUSH && mem.mem_ready);
    assign accept      = wr && !busy;
    assign same_line   = (line_of(addr) == line);
    assign merged_strb = line_strb | (8'b1 << addr[2:0]);

    assign rd_hit = (state != IDLE && line_of(rd_addr) == line) ||
                    (pend_valid && line_of(rd_addr) == pend_line);

    assign mem.mem_addr  = line;
    assign mem.mem_data  = line_data;
    assign mem.mem_strb  = line_strb;
    assign mem.mem_valid = (state == FLUSH);

`ifdef RAM_WRITE_TIMEOUT_EN
    logic [7:0] idle_cnt;

    assign timeout_hit = (state == FILL) && (idle_cnt == 8'(TIMEOUT_CYCLES - 1));

    // Idle counter: restarts on accepted writes and on FILL entry, counts in FILL.
    always_ff @(posedge clk_memory or negedge reset_n) begin
        if (!reset_n) begin
            idle_cnt <= '0;
        end else if (accept || (next_state == FILL && state != FILL)) begin
            idle_cnt <= '0;
        end else if (state == FILL) begin
            idle_cnt <= idle_cnt + 8'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    ram_wc_line_buffer u_line_buffer (
        .clk_memory (clk_memory),
        .reset_n    (reset_n),
        .op         (buf_op),
        .off        (buf_off),
        .byte_in    (buf_byte),
        .line_data  (line_data),
        .line_strb  (line_strb)
    );

    // State, line address and pending slot registers.
    always_ff @(posedge clk_memory or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            line       <= '0;
            pend_valid <= 1'b0;
            pend_line  <= '0;
            pend_off   <= '0;
            pend_byte  <= '0;
        end else begin
            state <= next_state;
            if (line_ld) begin
                line <= line_of(addr);
            end else if (pend_clr) begin
                line <= pend_line;
            end
            if (pend_set) begin
                pend_valid <= 1'b1;
                pend_line  <= line_of(addr);
                pend_off   <= addr[2:0];
                pend_byte  <= data;
            end else if (pend_clr) begin
                pend_valid <= 1'b0;
            end
        end
    end

    // Next state, buffer operation and pending-slot control.
    always_comb begin
        next_state = state;
        buf_op     = BUF_HOLD;
        buf_off    = addr[2:0];
        buf_byte   = data;
        line_ld    = 1'b0;
        pend_set   = 1'b0;
        pend_clr   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    buf_op     = BUF_LOAD;
                    line_ld    = 1'b1;
                    next_state = FILL;
                end
            end
            FILL: begin
                if (accept && same_line) begin
                    buf_op = BUF_MERGE;
                    if (merged_strb == '1 || flush || timeout_hit) begin
                        next_state = FLUSH;
                    end
                end else if (accept) begin
                    pend_set   = 1'b1;
                    next_state = FLUSH;
                end else if (flush || timeout_hit) begin
                    next_state = FLUSH;
                end
            end
            FLUSH: begin
                if (mem.mem_ready) begin
                    if (pend_valid) begin
                        buf_op     = BUF_LOAD;
                        buf_off    = pend_off;
                        buf_byte   = pend_byte;
                        pend_clr   = 1'b1;
                        next_state = FILL;
                    end else begin
                        buf_op     = BUF_CLEAR;
                        next_state = IDLE;
                    end
                end else if (accept) begin
                    // A different line arriving mid-flush is parked rather than lost.
                    if (same_line) begin
                        buf_op = BUF_MERGE;
                    end else begin
                        pend_set = 1'b1;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

endmodule
